// File: rtl/mem_stage_lsu_if.sv
// Data-memory port of the MEM-stage LSU: req/gnt request phase, rvalid/rdata response phase.
interface mem_stage_lsu_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: lane-steers stores, aligns/extends loads and stalls the
// pipeline across a variable-latency req/gnt/rvalid data-memory handshake.
module mem_stage_lsu #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_en_i,
  input  logic              st_en_i,
  input  logic              sb_i,
  input  logic              sh_i,
  input  logic              lb_i,
  input  logic              lh_i,
  input  logic              lbu_i,
  input  logic              lhu_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              ld_valid_o,
  output logic [DATA_W-1:0] ld_data_o,
  mem_stage_lsu_if.master   dmem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e            state_q, state_d;
  size_e             size_n, size_p0;
  logic              sext_n, sext_p0;
  logic              access_n, misal_n;
  logic [3:0]        be_n, be_p0;
  logic [DATA_W-1:0] wdata_n, wdata_p0, addr_p0;
  logic              we_p0;
  logic              launch, capture, stall, misal_flag, req, ld_valid;

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] rdata,
                                                input logic [1:0]        ofs,
                                                input size_e             sz,
                                                input logic              sext);
    logic        [DATA_W-1:0] sh;
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [DATA_W-1:0] sext_b, sext_h;
    sh     = rdata >> {ofs, 3'b000};
    b      = sh[7:0];
    h      = sh[15:0];
    sext_b = DATA_W'(b);
    sext_h = DATA_W'(h);
    case (sz)
      SZ_B:    extract = sext ? sext_b : {{(DATA_W-8){1'b0}}, sh[7:0]};
      SZ_H:    extract = sext ? sext_h : {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  // Decode: a store wins over a simultaneous load, so size comes from the store flags.
  always_comb begin
    access_n = ld_en_i | st_en_i;
    sext_n   = 1'b0;
    size_n   = SZ_W;
    if (st_en_i) begin
      if (sb_i)      size_n = SZ_B;
      else if (sh_i) size_n = SZ_H;
    end else begin
      if (lb_i | lbu_i)      size_n = SZ_B;
      else if (lh_i | lhu_i) size_n = SZ_H;
      sext_n = lb_i | lh_i;
    end
    misal_n = access_n & (((size_n == SZ_W) & (addr_i[1:0] != 2'b00)) |
                          ((size_n == SZ_H) & addr_i[0]));
    case (size_n)
      SZ_B:    be_n = 4'b0001 << addr_i[1:0];
      SZ_H:    be_n = addr_i[1] ? 4'b1100 : 4'b0011;
      default: be_n = 4'b1111;
    endcase
    case (size_n)
      SZ_B:    wdata_n = {4{wdata_i[7:0]}};
      SZ_H:    wdata_n = {2{wdata_i[15:0]}};
      default: wdata_n = wdata_i;
    endcase
  end

  // FSM next-state and handshake controls
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    misal_flag = 1'b0;
    req        = 1'b0;
    ld_valid   = 1'b0;
    launch     = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_n) begin
          if (misal_n) begin
            misal_flag = 1'b1;
          end else begin
            stall   = 1'b1;
            launch  = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dmem.gnt) state_d = we_p0 ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem.rvalid) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Pipeline advances on this edge; the next instruction is only seen back in IDLE.
        ld_valid = ~we_p0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // p0: control state and load result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      we_p0     <= 1'b0;
      ld_data_o <= '0;
    end else begin
      state_q <= state_d;
      if (launch)  we_p0     <= st_en_i;
      if (capture) ld_data_o <= extract(dmem.rdata, addr_p0[1:0], size_p0, sext_p0);
    end
  end

  // p0: request fields latched at launch, held stable until grant
  always_ff @(posedge clk_i) begin
    if (launch) begin
      addr_p0  <= addr_i;
      be_p0    <= be_n;
      wdata_p0 <= wdata_n;
      size_p0  <= size_n;
      sext_p0  <= sext_n;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign stall_o    = rst_ni & stall;
  assign misalign_o = rst_ni & misal_flag;
  assign ld_valid_o = ld_valid;

  assign dmem.req   = req;
  assign dmem.we    = req & we_p0;
  assign dmem.addr  = req ? {addr_p0[DATA_W-1:2], 2'b00} : '0;
  assign dmem.be    = req ? be_p0 : 4'b0000;
  assign dmem.wdata = req ? wdata_p0 : '0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: byte-addressed reference memory predicts requests
// and load results; a monitor compares whenever the DUT presents req or ld_valid.
module tb_mem_stage_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ld_en_i, st_en_i, sb_i, sh_i, lb_i, lh_i, lbu_i, lhu_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, misalign_o, ld_valid_o;
  logic [31:0] ld_data_o;

  mem_stage_lsu_if #(.DATA_W(32)) dmem_if ();

  mem_stage_lsu #(.DATA_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ld_en_i(ld_en_i), .st_en_i(st_en_i), .sb_i(sb_i), .sh_i(sh_i),
    .lb_i(lb_i), .lh_i(lh_i), .lbu_i(lbu_i), .lhu_i(lhu_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .misalign_o(misalign_o),
    .ld_valid_o(ld_valid_o), .ld_data_o(ld_data_o),
    .dmem(dmem_if.master)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] mem   [int];
  logic [7:0]  ref_b [int];
  int          gnt_dly = -1;
  int          rv_dly  = -1;
  bit          noise   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  function automatic logic [31:0] init_word(input int w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(input int w);
    if (mem.exists(w)) return mem[w];
    return init_word(w);
  endfunction

  function automatic logic [7:0] ref_byte(input int a);
    logic [31:0] w;
    if (ref_b.exists(a)) return ref_b[a];
    w = init_word(a >> 2);
    return 8'(w >> (8 * (a & 3)));
  endfunction

  task automatic preload(input int byte_addr, input logic [31:0] val);
    mem[byte_addr >> 2] = val;
    for (int i = 0; i < 4; i++) ref_b[byte_addr + i] = val[8*i +: 8];
  endtask

  task automatic clear_inputs();
    ld_en_i = 0; st_en_i = 0; sb_i = 0; sh_i = 0;
    lb_i = 0; lh_i = 0; lbu_i = 0; lhu_i = 0;
    addr_i = '0; wdata_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      clear_inputs();
    end
  endtask

  // Memory slave: grant after a chosen/random number of req cycles, respond later.
  initial begin
    int          req_cyc, rd_cnt, idx;
    logic [31:0] rd_word, w;
    req_cyc = 0; rd_cnt = 0; rd_word = '0;
    dmem_if.gnt = 0; dmem_if.rvalid = 0; dmem_if.rdata = '0;
    forever begin
      @(posedge clk_i); #1;
      dmem_if.gnt    = 0;
      dmem_if.rvalid = 0;
      dmem_if.rdata  = $urandom;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          dmem_if.rvalid = 1;
          dmem_if.rdata  = rd_word;
        end
      end else if (noise && $urandom_range(0, 7) == 0) begin
        dmem_if.rvalid = 1;
      end
      if (dmem_if.req) begin
        if (gnt_dly < 0 ? ($urandom_range(0, 2) == 0) : (req_cyc >= gnt_dly)) begin
          dmem_if.gnt = 1;
          req_cyc     = 0;
          idx         = int'(dmem_if.addr[31:2]);
          w           = mem_rd(idx);
          if (dmem_if.we) begin
            for (int i = 0; i < 4; i++)
              if (dmem_if.be[i]) w[8*i +: 8] = dmem_if.wdata[8*i +: 8];
            mem[idx] = w;
          end else begin
            rd_word = w;
            rd_cnt  = (rv_dly < 0) ? int'($urandom_range(1, 4)) : rv_dly;
          end
        end else begin
          req_cyc++;
        end
      end else begin
        req_cyc = 0;
      end
    end
  end

  // Monitor
  initial begin
    req_t e;
    forever begin
      @(negedge clk_i);
      if (dmem_if.req) begin
        if (req_q.size() == 0) begin
          check("unexpected dmem_req", 1, 0);
        end else begin
          e = req_q[0];
          check("dmem_we", dmem_if.we, e.we);
          check("dmem_addr", dmem_if.addr, e.addr);
          check("dmem_be", dmem_if.be, e.be);
          if (e.we) check("dmem_wdata", dmem_if.wdata, e.wdata);
          if (dmem_if.gnt) void'(req_q.pop_front());
        end
      end
      if (ld_valid_o) begin
        if (ld_q.size() == 0) check("unexpected ld_valid", 1, 0);
        else check("ld_data", ld_data_o, ld_q.pop_front());
      end
    end
  end

  // One MEM-stage instruction: hold it until the cycle stall_o is low.
  task automatic issue(input bit ld, input bit st, input int nb, input bit sgn,
                       input logic [31:0] a, input logic [31:0] wd, input int exp_stall);
    bit          misal;
    int          ofs, cyc;
    bit          done;
    req_t        e;
    longint      v;
    misal = (a % nb) != 0;
    ofs   = int'(a[1:0]);
    @(posedge clk_i); #1;
    ld_en_i = ld; st_en_i = st; addr_i = a; wdata_i = wd;
    sb_i = st && nb == 1;
    sh_i = st && nb == 2;
    if (st) begin
      {lb_i, lh_i, lbu_i, lhu_i} = 4'($urandom);
    end else begin
      lb_i  = nb == 1 && sgn;  lbu_i = nb == 1 && !sgn;
      lh_i  = nb == 2 && sgn;  lhu_i = nb == 2 && !sgn;
    end
    if (!misal) begin
      e.we = st;
      e.addr = {a[31:2], 2'b00};
      for (int i = 0; i < 4; i++) begin
        e.be[i] = (i >= ofs) && (i < ofs + nb);
        e.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
      end
      req_q.push_back(e);
      if (st) begin
        for (int i = 0; i < nb; i++) ref_b[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v |= longint'(ref_byte(int'(a) + i)) << (8 * i);
        if (sgn && v[8*nb-1]) v -= (longint'(1) << (8 * nb));
        ld_q.push_back(v[31:0]);
      end
    end
    cyc = 0; done = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_i);
      if (k == 0) begin
        check("misalign_o", misalign_o, misal);
        check("stall_o first cycle", stall_o, !misal);
      end
      if (!stall_o) begin done = 1; break; end
      cyc++;
    end
    if (!done) begin
      check("access completion timeout", 1, 0);
      finish_test();
    end
    if (exp_stall >= 0) check("stall cycles", cyc, exp_stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    rst_ni = 0;
    repeat (3) @(negedge clk_i);
    check("reset stall_o", stall_o, 0);
    check("reset misalign_o", misalign_o, 0);
    check("reset ld_valid_o", ld_valid_o, 0);
    check("reset ld_data_o", ld_data_o, 0);
    check("reset dmem_req", dmem_if.req, 0);
    check("reset dmem_we", dmem_if.we, 0);
    check("reset dmem_be", dmem_if.be, 0);
    check("reset dmem_addr", dmem_if.addr, 0);
    rst_ni = 1;

    // Directed cases
    gnt_dly = 2; rv_dly = 1; noise = 0;
    issue(0, 1, 4, 0, 32'h104, 32'hDEADBEEF, 4);
    preload(32'h100, 32'h0080FF00);
    gnt_dly = 0; rv_dly = 3;
    issue(1, 0, 1, 1, 32'h102, 32'h0, 5);
    rv_dly = 1;
    issue(1, 0, 2, 0, 32'h102, 32'h0, 3);
    issue(1, 0, 2, 1, 32'h100, 32'h0, 3);
    issue(0, 1, 1, 0, 32'h103, 32'h000000A5, 2);
    issue(1, 0, 4, 0, 32'h101, 32'h0, 0);
    issue(1, 1, 2, 0, 32'h106, 32'h1234CAFE, 2);
    issue(1, 0, 4, 0, 32'h104, 32'h0, 3);
    idle(2);
    check("ld_data held", ld_data_o, 32'hCAFEBEEF);

    // Reset while waiting for read data; the late rvalid must be ignored.
    gnt_dly = 0; rv_dly = 3;
    begin
      req_t e;
      bit   granted;
      @(posedge clk_i); #1;
      ld_en_i = 1; addr_i = 32'h200;
      e.we = 0; e.addr = 32'h200; e.be = 4'hF; e.wdata = '0;
      req_q.push_back(e);
      granted = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk_i);
        if (dmem_if.req && dmem_if.gnt) begin granted = 1; break; end
      end
      check("reset test grant seen", granted, 1);
      @(posedge clk_i); #3;
      check("wait stall before reset", stall_o, 1);
      rst_ni = 0; #1;
      check("async reset stall_o", stall_o, 0);
      check("async reset dmem_req", dmem_if.req, 0);
      check("async reset misalign_o", misalign_o, 0);
      ld_en_i = 0;
      @(negedge clk_i);
      rst_ni = 1;
      repeat (6) begin
        @(negedge clk_i);
        check("post reset ld_valid_o", ld_valid_o, 0);
        check("post reset dmem_req", dmem_if.req, 0);
      end
      check("post reset ld_data_o", ld_data_o, 0);
    end

    // Randomized traffic
    gnt_dly = -1; rv_dly = -1; noise = 1;
    for (int n = 0; n < 160; n++) begin
      int          op, nb;
      bit          ld, st, sgn;
      logic [31:0] a;
      op = int'($urandom_range(0, 8));
      case (op)
        0: begin ld = 0; st = 1; nb = 1; sgn = 0; end
        1: begin ld = 0; st = 1; nb = 2; sgn = 0; end
        2: begin ld = 0; st = 1; nb = 4; sgn = 0; end
        3: begin ld = 1; st = 0; nb = 1; sgn = 1; end
        4: begin ld = 1; st = 0; nb = 1; sgn = 0; end
        5: begin ld = 1; st = 0; nb = 2; sgn = 1; end
        6: begin ld = 1; st = 0; nb = 2; sgn = 0; end
        7: begin ld = 1; st = 0; nb = 4; sgn = 0; end
        default: begin
          ld = 1; st = 1; sgn = 0;
          nb = (int'($urandom_range(0, 2)) == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 2 : 4);
        end
      endcase
      a = 32'h100 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 32'd1);
      issue(ld, st, nb, sgn, a, $urandom, -1);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(10);
    check("request queue drained", req_q.size(), 0);
    check("load queue drained", ld_q.size(), 0);
    finish_test();
  end

endmodule
